// File: rtl/pixel_adjust_pkg.sv
// Shared types and saturation helper for the pixel adjust stream.
// The mode and state encodings are common to the top level and the per-channel lanes.
package pixel_adjust_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS   = 2'd0,
    MODE_BRIGHT   = 2'd1,
    MODE_CONTRAST = 2'd2,
    MODE_INVERT   = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  // Width of the signed value handed to sat_pw; must cover every lane intermediate.
  localparam int SAT_W = 32;

  // Clamp a signed value into the unsigned range 0 .. 2^pw-1.
  function automatic logic [SAT_W-1:0] sat_pw(input logic signed [SAT_W-1:0] value,
                                               input int unsigned pw);
    logic signed [SAT_W-1:0] max_val;
    max_val = signed'((SAT_W'(1) << pw) - SAT_W'(1));
    if (value < 0) return '0;
    if (value > max_val) return unsigned'(max_val);
    return unsigned'(value);
  endfunction

endpackage

// File: rtl/pixel_adjust_stream_if.sv
// Configuration, input stream, output stream and status signals of the pixel adjust unit.
// The slave modport is the unit's view; master is the source/sink side.
interface pixel_adjust_stream_if #(
  parameter int PW     = 8,
  parameter int CH     = 3,
  parameter int GAIN_W = 8
);
  logic [1:0]         cfg_mode;
  logic signed [PW:0] cfg_offset;
  logic [GAIN_W-1:0]  cfg_gain;

  logic               in_valid;
  logic               in_ready;
  logic [CH*PW-1:0]   in_data;

  logic               out_valid;
  logic               out_ready;
  logic [CH*PW-1:0]   out_data;
  logic               out_last;

  logic               frame_done;
  logic               busy;

  modport master (
    output cfg_mode, cfg_offset, cfg_gain,
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, frame_done, busy
  );

  modport slave (
    input  cfg_mode, cfg_offset, cfg_gain,
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, frame_done, busy
  );
endinterface

// File: rtl/pixel_adjust_lane.sv
// One channel of the adjust pipeline: stage 1 forms the product/sum terms,
// stage 2 shifts, adds and clamps. Both stages hold while stall is high.
module pixel_adjust_lane
  import pixel_adjust_pkg::*;
#(
  parameter int PW        = 8,
  parameter int GAIN_W    = 8,
  parameter int GAIN_FRAC = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  mode_t              mode,
  input  logic signed [PW:0] offset,
  input  logic [GAIN_W-1:0]  gain,
  input  logic [PW-1:0]      pix,
  output logic [PW-1:0]      result
);

  localparam int IW   = PW + GAIN_W + 2;
  localparam int MID  = 1 << (PW - 1);
  localparam int MAXV = (1 << PW) - 1;

  logic signed [IW-1:0] pix_s;
  logic signed [IW-1:0] off_s;
  logic signed [IW-1:0] gain_s;
  logic signed [IW-1:0] product;
  logic signed [IW-1:0] term_a_d, term_b_d;
  logic signed [IW-1:0] term_a_q, term_b_q;
  logic signed [IW-1:0] sum;
  logic                 shift_d, shift_q;

  assign pix_s   = signed'(IW'(pix));
  assign off_s   = IW'(offset);
  assign gain_s  = signed'(IW'(gain));
  assign product = (pix_s - IW'(MID)) * gain_s;

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    term_a_d = pix_s;
    term_b_d = '0;
    shift_d  = 1'b0;
    case (mode)
      MODE_BRIGHT:   term_b_d = off_s;
      MODE_CONTRAST: begin
        term_a_d = product;
        term_b_d = IW'(MID) + off_s;
        shift_d  = 1'b1;
      end
      MODE_INVERT:   term_a_d = IW'(MAXV) - pix_s;
      default:       ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      term_a_q <= '0;
      term_b_q <= '0;
      shift_q  <= 1'b0;
    end else if (!stall) begin
      term_a_q <= term_a_d;
      term_b_q <= term_b_d;
      shift_q  <= shift_d;
    end
  end

  // Arithmetic shift keeps the sign of the centred product (floor division).
  assign sum = (shift_q ? (term_a_q >>> GAIN_FRAC) : term_a_q) + term_b_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) result <= '0;
    else if (!stall) result <= PW'(sat_pw(SAT_W'(sum), PW));
  end

endmodule

// File: rtl/pixel_adjust_stream.sv
// Streaming brightness/contrast/invert unit: frame FSM, pixel counter, per-frame
// shadow config and the valid/last pipeline around CH arithmetic lanes.
module pixel_adjust_stream
  import pixel_adjust_pkg::*;
#(
  parameter int PW           = 8,
  parameter int CH           = 3,
  parameter int GAIN_W       = 8,
  parameter int GAIN_FRAC    = 4,
  parameter int FRAME_PIXELS = 1166400
) (
  input logic                 clk,
  input logic                 rst,
  pixel_adjust_stream_if.slave bus
);

  localparam int CNT_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q;
  mode_t              mode_q, mode_eff;
  logic signed [PW:0] offset_q, offset_eff;
  logic [GAIN_W-1:0]  gain_q, gain_eff;

  logic adv, accept, out_hs, frame_start, last_beat;
  logic s1_valid_q, s1_last_q, s2_valid_q, s2_last_q, frame_done_q;
  logic [PW-1:0] lane_out [CH];

  assign adv          = !s2_valid_q || bus.out_ready;
  assign bus.in_ready = adv && (state_q != DRAIN) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;
  assign out_hs       = s2_valid_q && bus.out_ready;
  assign frame_start  = (count_q == '0);
  assign last_beat    = (count_q == CNT_W'(FRAME_PIXELS - 1));

  // The first beat of a frame computes with live config, the same values captured into the shadow.
  assign mode_eff   = frame_start ? mode_t'(bus.cfg_mode) : mode_q;
  assign offset_eff = frame_start ? bus.cfg_offset : offset_q;
  assign gain_eff   = frame_start ? bus.cfg_gain : gain_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      mode_q   <= MODE_BYPASS;
      offset_q <= '0;
      gain_q   <= '0;
    end else if (accept) begin
      count_q <= last_beat ? '0 : count_q + CNT_W'(1);
      if (frame_start) begin
        mode_q   <= mode_eff;
        offset_q <= offset_eff;
        gain_q   <= gain_eff;
      end
    end
  end

  // Valid/last travel alongside the lane data; bubbles move as valid=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= accept;
      s1_last_q  <= accept && last_beat;
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= out_hs && s2_last_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ACTIVE;
      ACTIVE:  if (accept && last_beat) state_d = DRAIN;
      DRAIN:   if (out_hs && s2_last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  for (genvar c = 0; c < CH; c++) begin : g_lane
    pixel_adjust_lane #(
      .PW        (PW),
      .GAIN_W    (GAIN_W),
      .GAIN_FRAC (GAIN_FRAC)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .stall  (!adv),
      .mode   (mode_eff),
      .offset (offset_eff),
      .gain   (gain_eff),
      .pix    (bus.in_data[c*PW +: PW]),
      .result (lane_out[c])
    );
    assign bus.out_data[c*PW +: PW] = lane_out[c];
  end

  assign bus.out_valid  = s2_valid_q;
  assign bus.out_last   = s2_last_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_pixel_adjust_stream.sv
// Scoreboard bench for pixel_adjust_stream: a negedge monitor models each accepted
// beat and checks outputs, holds, drain readiness and frame_done timing.
module tb_pixel_adjust_stream;

  localparam int PW = 8, CH = 3, GAIN_W = 8, GAIN_FRAC = 4, FP = 16;
  localparam int DW = CH * PW;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic clk;
  logic rst;

  pixel_adjust_stream_if #(.PW(PW), .CH(CH), .GAIN_W(GAIN_W)) bus ();

  pixel_adjust_stream #(
    .PW(PW), .CH(CH), .GAIN_W(GAIN_W), .GAIN_FRAC(GAIN_FRAC), .FRAME_PIXELS(FP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  beat_t         exp_q[$];
  int            m_count = 0;
  logic [1:0]    m_mode = '0;
  int            m_off = 0, m_gain = 0;
  bit            draining = 0, exp_fd = 0, prev_stall = 0, rand_ready = 0;
  logic [DW-1:0] prev_data = '0, last_out = '0;
  logic          prev_last = 0;
  int            fd_count = 0, out_total = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic int clamp(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic logic [DW-1:0] model_pixel(input logic [DW-1:0] p, input logic [1:0] mode,
                                                input int off, input int gain);
    logic [DW-1:0] r;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      int s, v;
      s = int'(p[c*PW +: PW]);
      case (mode)
        2'd0:    v = s;
        2'd1:    v = clamp(s + off);
        2'd2:    v = clamp((((s - 128) * gain) >>> 4) + 128 + off);
        default: v = 255 - s;
      endcase
      r[c*PW +: PW] = v[PW-1:0];
    end
    return r;
  endfunction

  // Monitor: everything observed here transfers on the following rising edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_count = 0; draining = 0; exp_fd = 0; prev_stall = 0;
    end else begin
      checks++;
      if (bus.frame_done !== exp_fd) begin
        errors++;
        $display("FAIL frame_done got %b exp %b", bus.frame_done, exp_fd);
      end
      if (bus.frame_done) begin
        fd_count++;
        draining = 0;
      end
      if (draining) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL drain_ready got %b exp 0", bus.in_ready);
        end
      end
      if (prev_stall) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data || bus.out_last !== prev_last) begin
          errors++;
          $display("FAIL hold got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                   bus.out_valid, bus.out_data, bus.out_last, prev_data, prev_last);
        end
      end
      exp_fd = bus.out_valid && bus.out_ready && bus.out_last;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_output got %h exp none", bus.out_data);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          if (bus.out_data !== e.data || bus.out_last !== e.last) begin
            errors++;
            $display("FAIL out_beat got d=%h l=%b exp d=%h l=%b",
                     bus.out_data, bus.out_last, e.data, e.last);
          end
        end
        last_out = bus.out_data;
        out_total++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;
      if (bus.in_valid && bus.in_ready) begin
        beat_t b;
        if (m_count == 0) begin
          m_mode = bus.cfg_mode;
          m_off  = int'($signed(bus.cfg_offset));
          m_gain = int'(bus.cfg_gain);
        end
        b.last = (m_count == FP - 1);
        b.data = model_pixel(bus.in_data, m_mode, m_off, m_gain);
        exp_q.push_back(b);
        if (m_count == FP - 1) begin
          m_count = 0;
          draining = 1;
        end else m_count++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send_pixel(input logic [DW-1:0] d);
    int  n;
    bit  hs;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    forever begin
      @(negedge clk);
      hs = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (hs) break;
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL send_timeout got no accept exp accept within 200 cycles");
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_frame_done(input string name);
    int n;
    n = 0;
    while (n <= 300) begin
      @(negedge clk);
      if (bus.frame_done) break;
      n++;
    end
    checks++;
    if (n > 300) begin
      errors++;
      $display("FAIL %s frame_done got none exp pulse", name);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
    bus.cfg_mode = 0; bus.cfg_offset = '0; bus.cfg_gain = '0;
    #2;
    checks++;
    if (bus.in_ready !== 0 || bus.out_valid !== 0 || bus.out_last !== 0 ||
        bus.frame_done !== 0 || bus.busy !== 0 || bus.out_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs got r=%b v=%b l=%b fd=%b b=%b d=%h exp all 0",
               bus.in_ready, bus.out_valid, bus.out_last, bus.frame_done, bus.busy, bus.out_data);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got %b exp 1", bus.in_ready);
    end
  endtask

  task automatic test_brightness();
    logic [DW-1:0] px, ex;
    int base;
    px = {8'd100, 8'd250, 8'd0};
    ex = {8'd120, 8'd255, 8'd20};
    base = fd_count;
    bus.cfg_mode = 2'd1; bus.cfg_offset = 9'sd20; bus.out_ready = 1'b1;
    for (int i = 0; i < FP; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = px;
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL bright_start got r=%b b=%b exp r=1 b=0", bus.in_ready, bus.busy);
        end
      end
      if (i == 1) begin
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL bright_lat1 got v=%b b=%b exp v=0 b=1", bus.out_valid, bus.busy);
        end
      end
      if (i == 2) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== ex) begin
          errors++;
          $display("FAIL bright_lat2 got v=%b d=%h exp v=1 d=%h", bus.out_valid, bus.out_data, ex);
        end
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    wait_frame_done("bright");
    checks++;
    if (last_out !== ex || bus.busy !== 1'b0 || fd_count != base + 1) begin
      errors++;
      $display("FAIL bright_end got d=%h b=%b fd=%0d exp d=%h b=0 fd=%0d",
               last_out, bus.busy, fd_count, ex, base + 1);
    end
  endtask

  task automatic test_negative_and_contrast();
    logic [DW-1:0] ex;
    bus.cfg_mode = 2'd1; bus.cfg_offset = -9'sd30;
    for (int i = 0; i < FP; i++) send_pixel({8'd10, 8'd30, 8'd200});
    wait_frame_done("neg_offset");
    ex = {8'd0, 8'd0, 8'd170};
    checks++;
    if (last_out !== ex) begin
      errors++;
      $display("FAIL neg_offset got %h exp %h", last_out, ex);
    end
    bus.cfg_mode = 2'd2; bus.cfg_offset = 9'sd0; bus.cfg_gain = 8'd32;
    for (int i = 0; i < FP; i++) send_pixel({8'd192, 8'd64, 8'd128});
    wait_frame_done("contrast");
    ex = {8'd255, 8'd0, 8'd128};
    checks++;
    if (last_out !== ex) begin
      errors++;
      $display("FAIL contrast got %h exp %h", last_out, ex);
    end
  endtask

  task automatic test_invert_cfg_change();
    logic [DW-1:0] ex, px;
    bus.cfg_mode = 2'd3; bus.cfg_offset = 9'sd77;
    for (int i = 0; i < FP; i++) begin
      if (i == 5) bus.cfg_mode = 2'd0;
      send_pixel({8'd10, 8'd0, 8'd255});
    end
    wait_frame_done("invert");
    ex = {8'd245, 8'd255, 8'd0};
    checks++;
    if (last_out !== ex) begin
      errors++;
      $display("FAIL invert_hold_cfg got %h exp %h", last_out, ex);
    end
    px = '0;
    for (int i = 0; i < FP; i++) begin
      px = DW'($urandom);
      send_pixel(px);
    end
    wait_frame_done("bypass");
    checks++;
    if (last_out !== px) begin
      errors++;
      $display("FAIL bypass_next got %h exp %h", last_out, px);
    end
  endtask

  task automatic test_back_to_back_random();
    int base;
    base = fd_count;
    rand_ready = 1;
    for (int f = 0; f < 2; f++) begin
      bus.cfg_mode   = 2'($urandom_range(0, 3));
      bus.cfg_offset = 9'($urandom_range(0, 511));
      bus.cfg_gain   = 8'($urandom_range(0, 255));
      for (int i = 0; i < FP; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
        send_pixel(DW'($urandom));
      end
    end
    wait_frame_done("random");
    rand_ready = 0;
    bus.out_ready = 1'b1;
    checks++;
    if (fd_count != base + 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_frames got fd=%0d pend=%0d exp fd=%0d pend=0",
               fd_count, exp_q.size(), base + 2);
    end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    logic [DW-1:0] px;
    bus.cfg_mode = 2'd1; bus.cfg_offset = 9'sd5; bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) send_pixel(DW'($urandom));
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    base = fd_count;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got v=%b b=%b r=%b exp 0 0 0",
               bus.out_valid, bus.busy, bus.in_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bus.cfg_mode = 2'd3;
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (fd_count != base || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done got fd=%0d v=%b exp fd=%0d v=0", fd_count, bus.out_valid, base);
    end
    px = '0;
    for (int i = 0; i < FP; i++) begin
      px = DW'($urandom);
      send_pixel(px);
    end
    wait_frame_done("after_reset");
    checks++;
    if (fd_count != base + 1 || last_out !== ~px) begin
      errors++;
      $display("FAIL after_reset got fd=%0d d=%h exp fd=%0d d=%h", fd_count, last_out, base + 1, ~px);
    end
  endtask

  initial begin
    test_reset();
    test_brightness();
    test_negative_and_contrast();
    test_invert_cfg_change();
    test_back_to_back_random();
    test_reset_mid_frame();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty got %0d pending exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
